// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential word fetch over a req/ack memory port,
// DEPTH-entry {pc, instr} queue, redirect flush. `FETCH_PERF_CNT_EN adds perf counters.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_flushed_o,
    output logic [1:0]  state_o
);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        FULL    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d, count_np;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
    logic [31:0]   addr_q, addr_d, target_q, target_d;
    logic [31:0]   instr_q, instr_d, pc_q, pc_d;
    logic          req_q;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic          ack, pop, push, can_issue;
    logic [31:0]   redir_pc;

    // Memory handshake: mem_req_o and mem_addr_o stay stable from the cycle the request
    // is raised until the cycle mem_ack_i=1 (that cycle included, data valid with ack);
    // an ack while mem_req_o=0 is ignored, and only one request is ever outstanding.
    assign ack       = req_q && mem_ack_i;
    assign pop       = (count_q != '0) && !stall_i;
    assign push      = ack && (state_q == FETCH);
    assign count_np  = count_q + CW'(push) - CW'(pop);
    assign can_issue = start_i && (count_np < DEPTH_C);
    assign rd_next   = rd_ptr_q + PW'(pop);
    assign redir_pc  = redirect_pc_i & 32'hFFFF_FFFC;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        addr_d   = addr_q;
        target_d = target_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        if (redirect_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            case (state_q)
                FETCH, DISCARD: begin
                    if (ack) begin
                        addr_d  = redir_pc;
                        state_d = start_i ? FETCH : IDLE;
                    end else begin
                        // Old request must still complete; remember where to go afterwards.
                        target_d = redir_pc;
                        state_d  = DISCARD;
                    end
                end
                default: begin
                    addr_d  = redir_pc;
                    state_d = start_i ? FETCH : IDLE;
                end
            endcase
        end else begin
            count_d  = count_np;
            rd_ptr_d = rd_next;
            wr_ptr_d = wr_ptr_q + PW'(push);
            if (push) addr_d = addr_q + 32'd4;
            // Head register: bypass the incoming word when it becomes the new head.
            if (push && (count_q == CW'(pop))) begin
                instr_d = mem_data_i;
                pc_d    = addr_q;
            end else if (count_np != '0) begin
                instr_d = instr_mem_q[rd_next];
                pc_d    = pc_mem_q[rd_next];
            end
            case (state_q)
                IDLE: begin
                    if (can_issue) state_d = FETCH;
                end
                FETCH: begin
                    if (ack) state_d = can_issue ? FETCH : (start_i ? FULL : IDLE);
                end
                FULL: begin
                    if (can_issue)     state_d = FETCH;
                    else if (!start_i) state_d = IDLE;
                end
                default: begin
                    if (ack) begin
                        addr_d  = target_q;
                        state_d = start_i ? FETCH : IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            addr_q   <= RESET_PC;
            target_q <= RESET_PC;
            instr_q  <= '0;
            pc_q     <= '0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            req_q    <= (state_d == FETCH) || (state_d == DISCARD);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !redirect_i) begin
            instr_mem_q[wr_ptr_q] <= mem_data_i;
            pc_mem_q[wr_ptr_q]    <= addr_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, flushed_q, flush_inc;

    // Cleared entries on redirect, plus the returning word when it is thrown away.
    assign flush_inc = (redirect_i ? 32'(count_q) : 32'd0)
                     + 32'(ack && (redirect_i || (state_q == DISCARD)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(push && !redirect_i);
            flushed_q <= flushed_q + flush_inc;
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_flushed_o = flushed_q;
`else
    assign perf_fetched_o = '0;
    assign perf_flushed_o = '0;
`endif

    assign valid_o    = (count_q != '0);
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: zero-wait and 3-cycle memory, stall/full,
// redirects (idle, outstanding, same-cycle ack), PC wrap and asynchronous reset.
module tb_instr_fetch_queue;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        valid_o;
    logic [31:0] instr_o, pc_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] perf_fetched_o, perf_flushed_o;
    logic [1:0]  state_o;

    int total = 0;
    int bad = 0;
    int unsigned lat = 0;
    int unsigned wait_cnt;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .stall_i(stall_i), .valid_o(valid_o),
        .instr_o(instr_o), .pc_o(pc_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .perf_fetched_o(perf_fetched_o),
        .perf_flushed_o(perf_flushed_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after lat waiting cycles, returns addr + 100.
    assign mem_ack_i  = mem_req_o && (wait_cnt >= lat);
    assign mem_data_i = mem_addr_o + 32'd100;
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) wait_cnt <= 0;
        else if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic apply_reset;
        rst_i = 1'b1;
        redirect_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_i = 1'b1;
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", valid_o); end
        total++; if (instr_o !== 32'd0) begin bad++; $display("FAIL rst_instr got=%0h exp=0", instr_o); end
        total++; if (pc_o !== 32'd0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", pc_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", mem_req_o); end
        total++; if (mem_addr_o !== 32'd0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", mem_addr_o); end
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0h exp=0", state_o); end
        total++; if (perf_fetched_o !== 32'd0) begin bad++; $display("FAIL rst_fetched got=%0h exp=0", perf_fetched_o); end
        total++; if (perf_flushed_o !== 32'd0) begin bad++; $display("FAIL rst_flushed got=%0h exp=0", perf_flushed_o); end
    endtask

    task automatic test_sequential;
        lat = 0; start_i = 1'b1; stall_i = 1'b0;
        apply_reset();
        @(negedge clk);
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd0) begin bad++;
            $display("FAIL seq_first_req got=%0h/%0h exp=1/0", mem_req_o, mem_addr_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL seq_c1_valid got=%0h exp=0", valid_o); end
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL seq_valid k=%0d got=%0h exp=1", k, valid_o); end
            total++; if (pc_o !== 32'(4 * (k - 2))) begin bad++;
                $display("FAIL seq_pc k=%0d got=%0h exp=%0h", k, pc_o, 4 * (k - 2)); end
            total++; if (instr_o !== 32'(4 * (k - 2) + 100)) begin bad++;
                $display("FAIL seq_instr k=%0d got=%0h exp=%0h", k, instr_o, 4 * (k - 2) + 100); end
            total++; if (mem_addr_o !== 32'(4 * (k - 1))) begin bad++;
                $display("FAIL seq_addr k=%0d got=%0h exp=%0h", k, mem_addr_o, 4 * (k - 1)); end
        end
        total++; if (perf_fetched_o !== (PERF_EN ? 32'd6 : 32'd0)) begin bad++;
            $display("FAIL seq_fetched got=%0h exp=%0h", perf_fetched_o, PERF_EN ? 6 : 0); end
    endtask

    task automatic test_stall_full;
        int acks;
        lat = 0; start_i = 1'b1; stall_i = 1'b1;
        apply_reset();
        acks = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_req_o && mem_ack_i) acks++;
        end
        total++; if (acks != 4) begin bad++; $display("FAIL full_acks got=%0d exp=4", acks); end
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL full_state got=%0h exp=2", state_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL full_req got=%0h exp=0", mem_req_o); end
        total++; if (pc_o !== 32'd0 || instr_o !== 32'd100) begin bad++;
            $display("FAIL full_head got=%0h/%0h exp=0/64", pc_o, instr_o); end
        stall_i = 1'b0;
        @(negedge clk);
        stall_i = 1'b1;
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd16) begin bad++;
            $display("FAIL full_refill_req got=%0h/%0h exp=1/10", mem_req_o, mem_addr_o); end
        total++; if (pc_o !== 32'd4 || instr_o !== 32'd104) begin bad++;
            $display("FAIL full_pop_head got=%0h/%0h exp=4/68", pc_o, instr_o); end
        acks = (mem_req_o && mem_ack_i) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_req_o && mem_ack_i) acks++;
        end
        total++; if (acks != 1) begin bad++; $display("FAIL full_refill_acks got=%0d exp=1", acks); end
        total++; if (state_o !== 2'd2 || mem_addr_o !== 32'd20) begin bad++;
            $display("FAIL full_again got=%0h/%0h exp=2/14", state_o, mem_addr_o); end
    endtask

    task automatic test_redirect_idle;
        lat = 0; start_i = 1'b1; stall_i = 1'b1;
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        total++; if (state_o !== 2'd0 || mem_req_o !== 1'b0 || valid_o !== 1'b1) begin bad++;
            $display("FAIL rdi_pre got=%0h/%0h/%0h exp=0/0/1", state_o, mem_req_o, valid_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h40; start_i = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0; stall_i = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rdi_valid got=%0h exp=0", valid_o); end
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin bad++;
            $display("FAIL rdi_req got=%0h/%0h exp=1/40", mem_req_o, mem_addr_o); end
        total++; if (perf_flushed_o !== (PERF_EN ? 32'd3 : 32'd0)) begin bad++;
            $display("FAIL rdi_flushed got=%0h exp=%0h", perf_flushed_o, PERF_EN ? 3 : 0); end
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h40 || instr_o !== 32'hA4) begin bad++;
            $display("FAIL rdi_head got=%0h/%0h/%0h exp=1/40/a4", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_redirect_outstanding;
        lat = 3; start_i = 1'b0; stall_i = 1'b0;
        apply_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'h10; start_i = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10) begin bad++;
            $display("FAIL rdo_req got=%0h/%0h exp=1/10", mem_req_o, mem_addr_o); end
        @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h83;
        @(negedge clk);
        redirect_i = 1'b0;
        total++; if (state_o !== 2'd3 || mem_addr_o !== 32'h10 || mem_req_o !== 1'b1) begin bad++;
            $display("FAIL rdo_discard got=%0h/%0h/%0h exp=3/10/1", state_o, mem_addr_o, mem_req_o); end
        @(negedge clk);
        total++; if (mem_addr_o !== 32'h10) begin bad++; $display("FAIL rdo_hold got=%0h exp=10", mem_addr_o); end
        for (int i = 5; i <= 8; i++) begin
            @(negedge clk);
            total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rdo_dropped c=%0d got=%0h exp=0", i, valid_o); end
            if (i == 5) begin
                total++; if (mem_addr_o !== 32'h80 || mem_req_o !== 1'b1) begin bad++;
                    $display("FAIL rdo_new_req got=%0h/%0h exp=80/1", mem_addr_o, mem_req_o); end
                total++; if (perf_flushed_o !== (PERF_EN ? 32'd1 : 32'd0)) begin bad++;
                    $display("FAIL rdo_flushed got=%0h exp=%0h", perf_flushed_o, PERF_EN ? 1 : 0); end
            end
        end
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h80 || instr_o !== 32'hE4) begin bad++;
            $display("FAIL rdo_head got=%0h/%0h/%0h exp=1/80/e4", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_redirect_on_ack;
        lat = 0; start_i = 1'b1; stall_i = 1'b0;
        apply_reset();
        @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        @(negedge clk);
        redirect_i = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rda_valid got=%0h exp=0", valid_o); end
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin bad++;
            $display("FAIL rda_req got=%0h/%0h exp=1/200", mem_req_o, mem_addr_o); end
        total++; if (perf_fetched_o !== 32'd0) begin bad++; $display("FAIL rda_fetched got=%0h exp=0", perf_fetched_o); end
        total++; if (perf_flushed_o !== (PERF_EN ? 32'd1 : 32'd0)) begin bad++;
            $display("FAIL rda_flushed got=%0h exp=%0h", perf_flushed_o, PERF_EN ? 1 : 0); end
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== 32'h264) begin bad++;
            $display("FAIL rda_head got=%0h/%0h/%0h exp=1/200/264", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_pc_wrap;
        lat = 0; start_i = 1'b0; stall_i = 1'b0;
        apply_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF; start_i = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
        total++; if (mem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_align got=%0h exp=fffffffc", mem_addr_o); end
        @(negedge clk);
        total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_next got=%0h exp=0", mem_addr_o); end
        total++; if (pc_o !== 32'hFFFF_FFFC || instr_o !== 32'h60) begin bad++;
            $display("FAIL wrap_head got=%0h/%0h exp=fffffffc/60", pc_o, instr_o); end
    endtask

    task automatic test_async_reset;
        lat = 3; start_i = 1'b1; stall_i = 1'b0;
        apply_reset();
        for (int i = 1; i <= 5; i++) @(negedge clk);
        total++; if (valid_o !== 1'b1 || mem_addr_o !== 32'd4 || mem_req_o !== 1'b1) begin bad++;
            $display("FAIL ar_pre got=%0h/%0h/%0h exp=1/4/1", valid_o, mem_addr_o, mem_req_o); end
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        total++; if (valid_o !== 1'b0 || instr_o !== 32'd0 || pc_o !== 32'd0) begin bad++;
            $display("FAIL ar_head got=%0h/%0h/%0h exp=0/0/0", valid_o, instr_o, pc_o); end
        total++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'd0 || state_o !== 2'd0) begin bad++;
            $display("FAIL ar_req got=%0h/%0h/%0h exp=0/0/0", mem_req_o, mem_addr_o, state_o); end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd0 || state_o !== 2'd1) begin bad++;
            $display("FAIL ar_restart got=%0h/%0h/%0h exp=1/0/1", mem_req_o, mem_addr_o, state_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_full();
        test_redirect_idle();
        test_redirect_outstanding();
        test_redirect_on_ack();
        test_pc_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
